skid_stage_reg: RTL and testbench

SKID_STAGE_REG -- requirements
Module: skid_stage_reg

---
 rtl/skid_stage_reg.sv | 115 +++++++++++
 tb/tb_skid_stage_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/skid_stage_reg.sv
// Two-entry skid buffer register stage: registered valid/data toward the consumer,
// with a skid entry that holds the beat accepted while the consumer stalls.
module skid_stage_reg #(
  parameter int WIDTH          = 32,
  parameter int CNT_W          = 16,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             clr_stats
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic             head_valid, skid_valid;
  logic             in_fire, out_fire;

  assign head_valid = (state_reg != EMPTY);
  assign skid_valid = (state_reg == FULL);

  assign in_ready  = !skid_valid && !freeze;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = head_valid;
  assign out_fire  = head_valid && out_ready && !freeze;

  assign out_data  = head_reg;
  assign occupancy = 2'(state_reg);
  assign stall_cnt = stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= EMPTY;
      head_reg      <= '0;
      skid_reg      <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      head_reg      <= head_next;
      skid_reg      <= skid_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // freeze needs no branch of its own: it already suppresses both fire terms.
  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        head_next = '0;
        skid_next = '0;
      end
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            head_next  = in_data;
            state_next = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_next = in_data;
          end else if (in_fire) begin
            skid_next  = in_data;
            state_next = FULL;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            head_next  = skid_reg;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Stall statistics ignore flush so a flushed backlog still shows up as stall time.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (clr_stats) begin
      stall_cnt_next = '0;
    end else if (head_valid && !out_fire && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_skid_stage_reg.sv
// Bench for skid_stage_reg: two instances (clear-on-flush with 3-bit counter, retain with
// 16-bit counter) driven in lockstep and compared against a queue-based reference model.
module tb_skid_stage_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, flush, freeze, in_valid, out_ready, clr_stats;
  logic [W-1:0] in_data;

  logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [W-1:0] out_data_a, out_data_b;
  logic [1:0]   occ_a, occ_b;
  logic [2:0]   stall_a;
  logic [15:0]  stall_b;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of held beats plus the last value seen at the head.
  logic [W-1:0] q[$];
  logic [W-1:0] last_a, last_b;
  int           cnt_a, cnt_b;

  always #5 clk = ~clk;

  skid_stage_reg #(.WIDTH(W), .CNT_W(3), .CLEAR_ON_FLUSH(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
    .occupancy(occ_a), .stall_cnt(stall_a), .clr_stats(clr_stats)
  );

  skid_stage_reg #(.WIDTH(W), .CNT_W(16), .CLEAR_ON_FLUSH(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
    .occupancy(occ_b), .stall_cnt(stall_b), .clr_stats(clr_stats)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_a = '0;
    last_b = '0;
    cnt_a  = 0;
    cnt_b  = 0;
  endtask

  // Apply one clock edge's worth of the transfer rules to the model.
  task automatic model_step();
    bit ov, ir, of, inf;
    ov  = (q.size() > 0);
    ir  = (q.size() < 2) && !freeze;
    of  = ov && out_ready && !freeze;
    inf = in_valid && ir;
    if (clr_stats) begin
      cnt_a = 0;
      cnt_b = 0;
    end else if (ov && !of) begin
      if (cnt_a < 7) cnt_a++;
      if (cnt_b < 65535) cnt_b++;
    end
    if (flush) begin
      q.delete();
      last_a = '0;
    end else begin
      if (of) void'(q.pop_front());
      if (inf) q.push_back(in_data);
      if (q.size() > 0) begin
        last_a = q[0];
        last_b = q[0];
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] hd_a, hd_b;
    hd_a = (q.size() > 0) ? q[0] : last_a;
    hd_b = (q.size() > 0) ? q[0] : last_b;
    chk({tag, ".a.in_ready"},  32'(in_ready_a),  32'((q.size() < 2) && !freeze));
    chk({tag, ".a.out_valid"}, 32'(out_valid_a), 32'(q.size() > 0));
    chk({tag, ".a.out_data"},  32'(out_data_a),  32'(hd_a));
    chk({tag, ".a.occupancy"}, 32'(occ_a),       32'(q.size()));
    chk({tag, ".a.stall_cnt"}, 32'(stall_a),     32'(cnt_a));
    chk({tag, ".b.in_ready"},  32'(in_ready_b),  32'((q.size() < 2) && !freeze));
    chk({tag, ".b.out_valid"}, 32'(out_valid_b), 32'(q.size() > 0));
    chk({tag, ".b.out_data"},  32'(out_data_b),  32'(hd_b));
    chk({tag, ".b.occupancy"}, 32'(occ_b),       32'(q.size()));
    chk({tag, ".b.stall_cnt"}, 32'(stall_b),     32'(cnt_b));
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy,
                       input bit frz, input bit fl, input bit clr);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    freeze    = frz;
    flush     = fl;
    clr_stats = clr;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    $display("cyc t=%0t %s vin=%0b din=%0h ordy=%0b frz=%0b fl=%0b occ=%0d dout_a=%0h dout_b=%0h stall_a=%0d",
             $time, tag, in_valid, in_data, out_ready, freeze, flush, occ_a, out_data_a, out_data_b, stall_a);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, '0, 0, 0, 0, 0);
    model_reset();

    // Reset state, including in_ready following freeze while in reset.
    #12;
    check_all("reset");
    freeze = 1'b1;
    #1;
    chk("reset.freeze.in_ready", 32'(in_ready_a), 32'd0);
    freeze = 1'b0;
    rst    = 1'b0;

    // Streaming: first edge after reset accepts; one beat per cycle.
    for (int i = 1; i <= 4; i++) begin
      drive(1, W'(i), 1, 0, 0, 0);
      cycle("stream");
      chk("stream.data", 32'(out_data_a), 32'(i));
      chk("stream.occ", 32'(occ_a), 32'd1);
    end
    drive(0, '0, 1, 0, 0, 0);
    cycle("stream.drain");

    // Backpressure: A, B accepted, C waits upstream.
    drive(1, 8'hA1, 0, 0, 0, 0); cycle("bp.A");
    drive(1, 8'hB2, 0, 0, 0, 0); cycle("bp.B");
    chk("bp.full.in_ready", 32'(in_ready_a), 32'd0);
    drive(1, 8'hC3, 0, 0, 0, 0); cycle("bp.Cheld");
    chk("bp.occ", 32'(occ_a), 32'd2);
    drive(1, 8'hC3, 1, 0, 0, 0); cycle("bp.outA");
    chk("bp.head.B", 32'(out_data_a), 32'hB2);
    drive(1, 8'hC3, 1, 0, 0, 0); cycle("bp.outB");
    chk("bp.head.C", 32'(out_data_a), 32'hC3);
    drive(0, '0, 1, 0, 0, 0); cycle("bp.outC");

    // Freeze while full: nothing moves but stalls accumulate.
    drive(0, '0, 1, 0, 0, 1); cycle("frz.clr");
    drive(1, 8'h11, 0, 0, 0, 0); cycle("frz.fillA");
    drive(1, 8'h22, 0, 0, 0, 0); cycle("frz.fillB");
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h33, 1, 1, 0, 0);
      cycle("frz.hold");
    end
    drive(0, '0, 1, 0, 0, 0); cycle("frz.outA");
    drive(0, '0, 1, 0, 0, 0); cycle("frz.outB");

    // Flush overrides freeze and a concurrent offer.
    drive(1, 8'h5A, 0, 0, 0, 0); cycle("fl.fillA");
    drive(1, 8'h6B, 0, 0, 0, 0); cycle("fl.fillB");
    drive(1, 8'h7C, 1, 1, 1, 0); cycle("fl.flush");
    chk("fl.data.clear", 32'(out_data_a), 32'd0);
    chk("fl.data.keep", 32'(out_data_b), 32'h5A);
    chk("fl.valid", 32'(out_valid_b), 32'd0);

    // Saturation of the 3-bit counter, then clear.
    drive(1, 8'h99, 0, 0, 0, 1); cycle("sat.load");
    for (int i = 0; i < 10; i++) begin
      drive(0, '0, 0, 0, 0, 0);
      cycle("sat.stall");
    end
    chk("sat.a", 32'(stall_a), 32'd7);
    chk("sat.b", 32'(stall_b), 32'd10);
    drive(0, '0, 0, 0, 0, 1); cycle("sat.clr");
    chk("sat.clr.a", 32'(stall_a), 32'd0);

    // Asynchronous reset between edges while full.
    drive(1, 8'hE1, 0, 0, 0, 0); cycle("ar.fill");
    drive(0, '0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("ar.asserted");
    #1;
    rst = 1'b0;
    drive(1, 8'hF0, 1, 0, 0, 0); cycle("ar.first");
    chk("ar.first.data", 32'(out_data_a), 32'hF0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 49) == 0));
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
